usb_tx_sequencer: RTL and testbench

- Packet-level controller that drives the USB NRZI TX encoder (serial_out / new_bit / initiate / send_eop, eop_done back).
- Generates the bit-rate strobe and serialises SYNC, PID and payload bytes LSB-first with bit stuffing, then requests EOP.
- Pulls payload bytes from the TX FIFO through a valid/ready handshake and reports completion or underrun to the protocol layer.

---
 rtl/usb_tx_sequencer_if.sv | 28 ++
 rtl/usb_tx_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_sequencer_if.sv
// Signal bundle linking usb_tx_sequencer to the TX FIFO, the NRZI encoder and the protocol layer.
interface usb_tx_sequencer_if;
   logic       tx_start;
   logic [3:0] tx_pid;
   logic       tx_has_data;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_last;
   logic       tx_data_ready;
   logic       serial_out;
   logic       new_bit;
   logic       initiate;
   logic       send_eop;
   logic       eop_done;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (
      input  tx_start, tx_pid, tx_has_data, tx_data, tx_data_valid, tx_data_last, eop_done,
      output tx_data_ready, serial_out, new_bit, initiate, send_eop, tx_busy, tx_done, tx_error
   );

   modport slave (
      output tx_start, tx_pid, tx_has_data, tx_data, tx_data_valid, tx_data_last, eop_done,
      input  tx_data_ready, serial_out, new_bit, initiate, send_eop, tx_busy, tx_done, tx_error
   );
endinterface

// File: rtl/usb_tx_sequencer.sv
// USB packet TX sequencer: bit-rate strobe, SYNC/PID/payload serialisation with bit stuffing, EOP handshake.
// Define TX_CRC16_EN to append the inverted CRC16 trailer to packets whose pid[1:0] is 2'b11.
module usb_tx_sequencer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic               clk,
   input  logic               n_rst,
   usb_tx_sequencer_if.master bus
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_REQ, EOP_WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [2:0]    ones_q, ones_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          last_q, last_d;
   logic [3:0]    pid_q, pid_d;
   logic          has_data_q, has_data_d;
   logic          cur_bit_q, cur_bit_d;
   logic          fin_q, fin_d;
`ifdef TX_CRC16_EN
   logic [15:0]   crc_q, crc_d;
`endif

   logic       busy, new_bit, initiate, data_ready, underrun;
   logic       emit, bit_v, ended, crc_pkt;
   logic [7:0] pid_byte;

   assign pid_byte = {~pid_q, pid_q};

`ifdef TX_CRC16_EN
   assign crc_pkt = (pid_q[1:0] == 2'b11);

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
      logic fb;
      fb = d ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction
`else
   assign crc_pkt = 1'b0;
`endif

   // The state/bit_cnt pair always names the bit that the next strobe will carry.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_cnt_d  = bit_cnt_q;
      ones_d     = ones_q;
      shreg_d    = shreg_q;
      last_d     = last_q;
      pid_d      = pid_q;
      has_data_d = has_data_q;
      cur_bit_d  = cur_bit_q;
      fin_d      = fin_q;
`ifdef TX_CRC16_EN
      crc_d      = crc_q;
`endif
      busy       = (state_q != IDLE) && (state_q != DONE);
      new_bit    = busy && (timer_q == TMAX);
      initiate   = 1'b0;
      data_ready = 1'b0;
      underrun   = 1'b0;
      emit       = 1'b0;
      bit_v      = 1'b0;
      ended      = 1'b0;

      if (busy) timer_d = new_bit ? '0 : timer_q + TW'(1);

      case (state_q)
         IDLE: begin
            if (bus.tx_start) begin
               initiate   = 1'b1;
               emit       = 1'b1;
               bit_v      = 1'b0;
               pid_d      = bus.tx_pid;
               has_data_d = bus.tx_has_data;
               bit_cnt_d  = 4'd1;
               ones_d     = 3'd0;
               fin_d      = 1'b0;
               timer_d    = '0;
`ifdef TX_CRC16_EN
               crc_d      = 16'hFFFF;
`endif
               state_d    = SYNC;
            end
         end

         SYNC, PID, DATA, CRC: begin
            if (new_bit) begin
               if (ones_q == 3'd6) begin
                  // Stuffed zero: field position is held, only the ones run restarts.
                  emit   = 1'b1;
                  bit_v  = 1'b0;
                  ones_d = 3'd0;
                  if (fin_q) state_d = EOP_REQ;
               end else begin
                  if (state_q == SYNC) begin
                     emit  = 1'b1;
                     bit_v = (bit_cnt_q == 4'd7);
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = PID;
                     end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                     end
                  end else if (state_q == PID) begin
                     emit  = 1'b1;
                     bit_v = pid_byte[bit_cnt_q[2:0]];
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (has_data_q)   state_d = DATA;
                        else if (crc_pkt) state_d = CRC;
                        else              ended   = 1'b1;
                     end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                     end
                  end else if (state_q == DATA) begin
                     if (bit_cnt_q == 4'd0) begin
                        if (!bus.tx_data_valid) begin
                           underrun = 1'b1;
                           state_d  = EOP_REQ;
                        end else begin
                           data_ready = 1'b1;
                           emit       = 1'b1;
                           bit_v      = bus.tx_data[0];
                           shreg_d    = bus.tx_data;
                           last_d     = bus.tx_data_last;
                           bit_cnt_d  = 4'd1;
                        end
                     end else begin
                        emit  = 1'b1;
                        bit_v = shreg_q[bit_cnt_q[2:0]];
                        if (bit_cnt_q == 4'd7) begin
                           bit_cnt_d = 4'd0;
                           if (last_q) begin
                              if (crc_pkt) state_d = CRC;
                              else         ended   = 1'b1;
                           end
                        end else begin
                           bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                     end
`ifdef TX_CRC16_EN
                     if (emit) crc_d = crc16_step(crc_q, bit_v);
`endif
                  end else begin
`ifdef TX_CRC16_EN
                     emit  = 1'b1;
                     bit_v = ~crc_q[15];
                     crc_d = {crc_q[14:0], 1'b0};
                     if (bit_cnt_q == 4'd15) ended = 1'b1;
                     else                    bit_cnt_d = bit_cnt_q + 4'd1;
`else
                     state_d = EOP_REQ;
`endif
                  end

                  if (emit) ones_d = bit_v ? ones_q + 3'd1 : 3'd0;
                  // A final bit that completes a run of six still owes its stuffed zero before EOP.
                  if (ended) begin
                     bit_cnt_d = 4'd0;
                     if (bit_v && (ones_q == 3'd5)) fin_d   = 1'b1;
                     else                           state_d = EOP_REQ;
                  end
               end
            end
         end

         EOP_REQ: state_d = EOP_WAIT;

         EOP_WAIT: begin
            if (new_bit) begin
               emit  = 1'b1;
               bit_v = 1'b1;
            end
            if (bus.eop_done) state_d = DONE;
         end

         DONE: begin
            state_d   = IDLE;
            cur_bit_d = 1'b0;
            timer_d   = '0;
            ones_d    = 3'd0;
            bit_cnt_d = 4'd0;
            fin_d     = 1'b0;
         end

         default: state_d = IDLE;
      endcase

      if (emit) cur_bit_d = bit_v;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bit_cnt_q  <= 4'd0;
         ones_q     <= 3'd0;
         shreg_q    <= 8'd0;
         last_q     <= 1'b0;
         pid_q      <= 4'd0;
         has_data_q <= 1'b0;
         cur_bit_q  <= 1'b0;
         fin_q      <= 1'b0;
`ifdef TX_CRC16_EN
         crc_q      <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_cnt_q  <= bit_cnt_d;
         ones_q     <= ones_d;
         shreg_q    <= shreg_d;
         last_q     <= last_d;
         pid_q      <= pid_d;
         has_data_q <= has_data_d;
         cur_bit_q  <= cur_bit_d;
         fin_q      <= fin_d;
`ifdef TX_CRC16_EN
         crc_q      <= crc_d;
`endif
      end
   end

   assign bus.serial_out    = emit ? bit_v : cur_bit_q;
   assign bus.new_bit       = new_bit;
   assign bus.initiate      = initiate;
   assign bus.send_eop      = (state_q == EOP_REQ);
   assign bus.tx_busy       = busy;
   assign bus.tx_done       = (state_q == DONE);
   assign bus.tx_error      = underrun;
   assign bus.tx_data_ready = data_ready;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: directed packets push expected bits/events, a monitor pops and compares.
module tb_usb_tx_sequencer;
   localparam int CPB = 8;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   usb_tx_sequencer_if bus ();

   usb_tx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   int exp_bits[$];
   int exp_rdy[$];
   int exp_err[$];
   int exp_eop[$];
   int exp_done[$];
   logic [8:0] fifo[$];
   bit sb_en = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic int outs();
      return int'({bus.tx_data_ready, bus.serial_out, bus.new_bit, bus.initiate,
                   bus.send_eop, bus.tx_busy, bus.tx_done, bus.tx_error});
   endfunction

   task automatic fifo_drive();
      bus.tx_data_valid = (fifo.size() > 0);
      bus.tx_data       = (fifo.size() > 0) ? fifo[0][7:0] : 8'h00;
      bus.tx_data_last  = (fifo.size() > 0) ? fifo[0][8] : 1'b0;
   endtask

   task automatic clear_sb();
      exp_bits.delete(); exp_rdy.delete(); exp_err.delete(); exp_eop.delete(); exp_done.delete();
   endtask

   // FIFO model: pops the head after a cycle in which the DUT strobed tx_data_ready.
   initial begin
      bit pop;
      forever begin
         @(negedge clk);
         pop = bus.tx_data_ready;
         @(posedge clk);
         #1;
         if (pop && fifo.size() > 0) void'(fifo.pop_front());
         fifo_drive();
      end
   end

   // Encoder model: answers each EOP request with a one-cycle eop_done a few cycles later.
   initial begin
      bus.eop_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.send_eop && n_rst) begin
            repeat (4) @(posedge clk);
            #1 bus.eop_done = 1'b1;
            @(posedge clk);
            #1 bus.eop_done = 1'b0;
         end
      end
   end

   // Monitor
   initial begin
      bit in_pkt = 1'b0;
      bit eop_seen = 1'b0;
      int slot = 0;
      int last_strobe = 0;
      int eop_cyc = 0;
      logic held = 1'b0;
      forever begin
         @(negedge clk);
         if (!n_rst || !sb_en) begin
            in_pkt   = 1'b0;
            eop_seen = 1'b0;
         end else begin
            if (bus.initiate) begin
               in_pkt = 1'b1; eop_seen = 1'b0; slot = 0; last_strobe = cyc;
               if (exp_bits.size() == 0) check("bit_unexpected", 1, 0);
               else check("bit_slot0", int'(bus.serial_out), exp_bits.pop_front());
               held = bus.serial_out;
            end else if (bus.new_bit && in_pkt) begin
               check("bit_period", cyc - last_strobe, CPB);
               last_strobe = cyc;
               slot++;
               if (!eop_seen) begin
                  if (bus.tx_error) begin
                     if (exp_err.size() == 0) check("err_unexpected", 1, 0);
                     else check("err_slot", slot, exp_err.pop_front());
                  end else begin
                     if (exp_bits.size() == 0) check("bit_unexpected", 1, 0);
                     else check($sformatf("bit_slot%0d", slot), int'(bus.serial_out), exp_bits.pop_front());
                     held = bus.serial_out;
                  end
               end
            end else if (in_pkt && !eop_seen) begin
               check("serial_hold", int'(bus.serial_out), int'(held));
            end

            if (bus.tx_error && !bus.new_bit) check("err_off_strobe", 1, 0);

            if (bus.tx_data_ready) begin
               check("ready_on_strobe", int'(bus.new_bit), 1);
               if (exp_rdy.size() == 0) check("ready_unexpected", 1, 0);
               else check("ready_slot", slot, exp_rdy.pop_front());
            end

            if (bus.send_eop) begin
               if (exp_eop.size() == 0) check("eop_unexpected", 1, 0);
               else check("eop_slot", slot, exp_eop.pop_front());
               check("eop_gap", cyc - last_strobe, 1);
               eop_seen = 1'b1;
            end

            if (bus.eop_done) eop_cyc = cyc;

            if (bus.tx_done) begin
               if (exp_done.size() == 0) check("done_unexpected", 1, 0);
               else begin
                  void'(exp_done.pop_front());
                  check("done_gap", cyc - eop_cyc, 1);
                  check("done_busy", int'(bus.tx_busy), 0);
                  check("done_new_bit", int'(bus.new_bit), 0);
               end
               in_pkt = 1'b0;
            end
         end
      end
   end

   task automatic run_pkt(input string tag, input logic [3:0] pid, input logic hd,
                          input logic [63:0] bits, input int nbits, input int rdy_a,
                          input int rdy_b, input int err_slot, input int eop_slot,
                          input bit start_in_done);
      int guard;
      for (int i = 0; i < nbits; i++) exp_bits.push_back(int'(bits[nbits-1-i]));
      if (rdy_a >= 0) exp_rdy.push_back(rdy_a);
      if (rdy_b >= 0) exp_rdy.push_back(rdy_b);
      if (err_slot >= 0) exp_err.push_back(err_slot);
      exp_eop.push_back(eop_slot);
      exp_done.push_back(1);

      @(posedge clk);
      #1;
      bus.tx_pid = pid; bus.tx_has_data = hd; bus.tx_start = 1'b1;
      @(negedge clk);
      check({tag, "_initiate"}, int'(bus.initiate), 1);
      check({tag, "_sync_bit0"}, int'(bus.serial_out), 0);
      @(posedge clk);
      #1 bus.tx_start = 1'b0;
      @(negedge clk);
      check({tag, "_busy"}, int'(bus.tx_busy), 1);

      guard = 0;
      while (!bus.tx_done && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check({tag, "_finished"}, int'(guard < 2000), 1);

      if (start_in_done && bus.tx_done) begin
         bus.tx_start = 1'b1;
         @(negedge clk);
         check({tag, "_start_in_done"}, int'(bus.initiate), 0);
         @(posedge clk);
         #1 bus.tx_start = 1'b0;
         @(negedge clk);
         check({tag, "_idle_after_done"}, int'(bus.tx_busy), 0);
      end

      repeat (3) @(posedge clk);
      check({tag, "_bits_left"}, exp_bits.size(), 0);
      check({tag, "_ready_left"}, exp_rdy.size(), 0);
      check({tag, "_err_left"}, exp_err.size(), 0);
      check({tag, "_eop_left"}, exp_eop.size(), 0);
      check({tag, "_done_left"}, exp_done.size(), 0);
      clear_sb();
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.tx_start = 1'b0;
      bus.tx_pid = 4'd0;
      bus.tx_has_data = 1'b0;
      fifo_drive();
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", outs(), 0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      @(negedge clk);
      check("idle_outputs", outs(), 0);

      // Token: SYNC then PID 0x69 LSB-first; start attempted in the DONE cycle.
      run_pkt("token", 4'b1001, 1'b0, 64'b0000000110010110, 16, -1, -1, -1, 15, 1'b1);

`ifdef TX_CRC16_EN
      // Zero-length DATA PID: trailer is ~0xFFFF, sixteen zeros.
      run_pkt("crc_zero", 4'b0011, 1'b0, 64'b00000001110000110000000000000000, 32, -1, -1, -1, 31, 1'b0);
`else
      // 0xFF payload: a stuffed zero after the sixth consecutive one.
      fifo.push_back({1'b1, 8'hFF});
      fifo_drive();
      run_pkt("stuff_ff", 4'b0011, 1'b1, 64'b0000000111000011111101111, 25, 16, -1, -1, 24, 1'b0);

      fifo.push_back({1'b0, 8'h01});
      fifo.push_back({1'b1, 8'h02});
      fifo_drive();
      run_pkt("two_bytes", 4'b0011, 1'b1, 64'b00000001110000111000000001000000, 32, 16, 24, -1, 31, 1'b0);
`endif

      // Underrun: FIFO empty at the first payload slot.
      fifo.delete();
      fifo_drive();
      run_pkt("underrun", 4'b0011, 1'b1, 64'b0000000111000011, 16, -1, -1, 16, 16, 1'b0);

      // Reset abort in the middle of DATA, then a fresh packet.
      sb_en = 1'b0;
      fifo.push_back({1'b0, 8'h55});
      fifo.push_back({1'b1, 8'hAA});
      fifo_drive();
      @(posedge clk);
      #1;
      bus.tx_pid = 4'b0011; bus.tx_has_data = 1'b1; bus.tx_start = 1'b1;
      @(posedge clk);
      #1 bus.tx_start = 1'b0;
      repeat (150) @(posedge clk);
      @(negedge clk);
      check("abort_busy_before", int'(bus.tx_busy), 1);
      #1 n_rst = 1'b0;
      #1 check("abort_outputs", outs(), 0);
      @(negedge clk);
      check("abort_outputs_held", outs(), 0);
      fifo.delete();
      fifo_drive();
      clear_sb();
      @(posedge clk);
      #1 n_rst = 1'b1;
      sb_en = 1'b1;

      run_pkt("restart", 4'b1001, 1'b0, 64'b0000000110010110, 16, -1, -1, -1, 15, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
